cordic_ctrl_fsm_p: RTL and testbench
====================================

// Module: cordic_ctrl_fsm_p
// PURPOSE
//  Parametrised CORDIC sequencer, next generation of the CORDIC control FSM. Owns its own iteration and
//  variable counters (no external tick inputs) and supports rotation or vectoring mode per operation.
//  Drives the X/Y/Z datapath through the shared add/subt unit with a start/ready/ack handshake.
//  Sits between the host interface and the CORDIC datapath (mux selects, register enables, LUT/sign/shift regs).
// PARAMETERS
//  N_ITER   16  CORDIC iterations per operation (>=2)
//  ITER_W   5   iteration index width, >= clog2(N_ITER)
//  N_VAR    3   variables updated per iteration (2 or 3; 3 = X,Y,Z)
// PORTS
//  clk              in   1        system clock, rising edge
//  reset            in   1        asynchronous, active-low reset
//  beg_fsm_cordic   in   1        start request, level, sampled in IDLE only
//  ack_fsm_cordic   in   1        host has taken the result
//  operation        in   1        0 = cosine, 1 = sine
//  mode_in          in   1        0 = rotation, 1 = vectoring; latched at LOAD
//  shift_region_flag in  2        angle range-reduction region; latched at LOAD
//  ready_add_subt   in   1        add/subt result valid
//  ready_mult       in   1        gain multiplier done (CORDIC_GAIN_COMP_EN only)
//  ready_cordic     out  1        result valid, held until ack
//  busy             out  1        high in every state except IDLE and DONE
//  beg_add_subt     out  1        one-cycle start pulse to add/subt
//  ack_add_subt     out  1        one-cycle result-consumed pulse to add/subt
//  beg_mult         out  1        one-cycle start pulse to gain multiplier (CORDIC_GAIN_COMP_EN only)
//  iter_idx         out  ITER_W   current iteration (shift amount / LUT address)
//  var_idx          out  2        current variable: 0 = X, 1 = Y, 2 = Z
//  sel_mux_1        out  1        0 in iteration 0 (initial values), 1 otherwise
//  sel_mux_2        out  2        equals var_idx
//  sel_mux_3        out  1        operation ^ (shift_region_flag==2'b01 || shift_region_flag==2'b10)
//  mode             out  1        latched mode_in
//  enab_rb1, enab_rb2, enab_d_ff_xn, enab_d_ff_yn, enab_d_ff_zn, enab_dff_shifted, enab_dff_lut,
//  enab_dff_sign, enab_d_ff_out
//                   out  1 each   one-cycle register enables
// BEHAVIOUR
//  Reset: state IDLE, counters 0, every output 0. Reset asserted mid-operation aborts immediately; no partial ready.
//  States and transitions:
//   IDLE     -> LOAD when beg_fsm_cordic=1
//   LOAD     enab_rb1; latch mode/region -> SETUP
//   SETUP    enab_rb2, enab_dff_shifted, enab_dff_lut, enab_dff_sign; var_idx<=0 -> ADD_ST
//   ADD_ST   beg_add_subt=1 -> ADD_WT
//   ADD_WT   hold while ready_add_subt=0 -> STORE
//   STORE    enab_d_ff_{x,y,z}n for var_idx; ack_add_subt=1
//            more vars left: var_idx++ -> ADD_ST
//            last var, iter_idx<N_ITER-1: iter_idx++ -> SETUP
//            last var, last iter -> OUT (or GAIN)
//   OUT      enab_d_ff_out -> DONE
//   DONE     ready_cordic=1 -> IDLE when ack_fsm_cordic=1
//  Latency: beg to ready_cordic = 2 + N_ITER*(1 + N_VAR*(2+W)) + 1 cycles, where W is ADD_WT cycles (>=1).
//  Boundary rules:
//   beg while busy or in DONE is ignored. ack outside DONE is ignored.
//   beg and ack both high in DONE: ack wins, FSM goes to IDLE; a new start needs beg sampled in IDLE.
//   ready_add_subt seen outside ADD_WT is ignored.
//   iter_idx never wraps: it saturates at N_ITER-1, and the FSM leaves the loop there.
// CONFIGURATION
//  CORDIC_GAIN_COMP_EN defined: OUT is preceded by GAIN (beg_mult pulse) and GWT (wait for ready_mult).
//   The K-gain correction adds 1+Wm cycles.
//  Not defined: no GAIN/GWT states; beg_mult tied to 0; ready_mult is not a port.
// STRUCTURE
//  Shared include cordic_defs.vh holds state encodings (localparam), VAR_X/VAR_Y/VAR_Z, and MODE_ROT/MODE_VEC.
//  One sub-module, cordic_cnt_p: parametrised up-counter with load, enable, max_tick and min_tick.
//   It is instantiated twice, once for iterations and once for variables.
// TESTING
//  1 N_ITER=4, N_VAR=3, ready_add_subt 1 cycle after every beg_add_subt -> 12 beg pulses, ready_cordic at cycle 2+4*(1+3*3)+1=43.
//  2 operation=1, region=2'b01 -> sel_mux_3=0. operation=0, region=2'b00 -> sel_mux_3=0. operation=0, region=2'b10 -> sel_mux_3=1.
//  3 ack held 0 for 20 cycles in DONE -> ready_cordic stays 1. ack=1 -> IDLE next cycle, ready_cordic=0.
//  4 reset low during iteration 2 -> all outputs 0 asynchronously; beg after release restarts at iter_idx=0, sel_mux_1=0.
//  5 beg pulsed while busy, plus a spurious ready_add_subt in SETUP -> no state change, no extra enab_d_ff_*n.
//  6 CORDIC_GAIN_COMP_EN, ready_mult 3 cycles after beg_mult -> ready_cordic delayed by exactly 4 cycles vs test 1.

Source files
------------

// File: rtl/cordic_ctrl_fsm_p_pkg.sv
// Shared definitions for the CORDIC sequencer: state encoding, variable
// indices, mode encodings and the range-reduction helper used by sel_mux_3.
package cordic_ctrl_fsm_p_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_ADD_ST,
    ST_ADD_WT,
    ST_STORE,
    ST_GAIN,
    ST_GWT,
    ST_OUT,
    ST_DONE
  } state_e;

  localparam logic [1:0] VAR_X = 2'd0;
  localparam logic [1:0] VAR_Y = 2'd1;
  localparam logic [1:0] VAR_Z = 2'd2;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Regions 01 and 10 mirror the angle, which swaps the sin/cos output select.
  function automatic logic region_swaps(input logic [1:0] region);
    return (region == 2'b01) || (region == 2'b10);
  endfunction

endpackage

// File: rtl/cordic_ctrl_fsm_p_cnt.sv
// cordic_cnt_p: saturating up-counter with synchronous load.
// Ports: clk, rst_n (async active-low), load/ld_val (sync load, wins over en),
//        en (count up, holds at MAX), cnt, max_tick (cnt==MAX), min_tick (cnt==0).
module cordic_cnt_p #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         max_tick,
  output logic         min_tick
);

  assign max_tick = (cnt == MAX);
  assign min_tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (load)             cnt <= ld_val;
    else if (en && !max_tick)  cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/cordic_ctrl_fsm_p.sv
// cordic_ctrl_fsm_p: CORDIC sequencer. Walks N_ITER iterations, each updating
// N_VAR variables through the shared add/subt unit (beg/ready/ack handshake),
// and drives datapath mux selects and register enables.
// Ports:
//   clk, reset (async active-low)
//   host:    beg_fsm_cordic, ack_fsm_cordic, operation, mode_in,
//            shift_region_flag -> ready_cordic, busy
//   add/sub: beg_add_subt, ack_add_subt <- ready_add_subt
//   gain:    beg_mult (<- ready_mult when CORDIC_GAIN_COMP_EN is defined)
//   datapath: iter_idx, var_idx, sel_mux_1/2/3, mode, enab_* one-cycle enables
// Build option: CORDIC_GAIN_COMP_EN inserts GAIN/GWT (K-gain multiply) before OUT.
module cordic_ctrl_fsm_p
  import cordic_ctrl_fsm_p_pkg::*;
#(
  parameter int N_ITER = 16,
  parameter int ITER_W = 5,
  parameter int N_VAR  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beg_fsm_cordic,
  input  logic              ack_fsm_cordic,
  input  logic              operation,
  input  logic              mode_in,
  input  logic [1:0]        shift_region_flag,
  input  logic              ready_add_subt,
`ifdef CORDIC_GAIN_COMP_EN
  input  logic              ready_mult,
`endif
  output logic              ready_cordic,
  output logic              busy,
  output logic              beg_add_subt,
  output logic              ack_add_subt,
  output logic              beg_mult,
  output logic [ITER_W-1:0] iter_idx,
  output logic [1:0]        var_idx,
  output logic              sel_mux_1,
  output logic [1:0]        sel_mux_2,
  output logic              sel_mux_3,
  output logic              mode,
  output logic              enab_rb1,
  output logic              enab_rb2,
  output logic              enab_d_ff_xn,
  output logic              enab_d_ff_yn,
  output logic              enab_d_ff_zn,
  output logic              enab_dff_shifted,
  output logic              enab_dff_lut,
  output logic              enab_dff_sign,
  output logic              enab_d_ff_out
);

  localparam logic [ITER_W-1:0] ITER_MAX = ITER_W'(N_ITER - 1);
  localparam logic [1:0]        VAR_MAX  = 2'(N_VAR - 1);

  state_e     state, state_nxt;
  logic       iter_last, iter_first, var_last, unused_var_min;
  logic       op_q;
  logic [1:0] region_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Counters are cleared while idle so every operation starts at (0,0);
  // the variable counter is also rewound at the top of each iteration.
  cordic_cnt_p #(.W(ITER_W), .MAX(ITER_MAX)) u_iter_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (state == ST_IDLE),
    .ld_val   ('0),
    .en       ((state == ST_STORE) && var_last),
    .cnt      (iter_idx),
    .max_tick (iter_last),
    .min_tick (iter_first)
  );

  cordic_cnt_p #(.W(2), .MAX(VAR_MAX)) u_var_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     ((state == ST_IDLE) || (state == ST_SETUP)),
    .ld_val   (2'b00),
    .en       ((state == ST_STORE) && !var_last),
    .cnt      (var_idx),
    .max_tick (var_last),
    .min_tick (unused_var_min)
  );

  // Per-operation configuration captured once so the host may change its
  // inputs while the operation runs. Cleared on reset so outputs read 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode     <= MODE_ROT;
      op_q     <= 1'b0;
      region_q <= 2'b00;
    end else if (state == ST_LOAD) begin
      mode     <= mode_in;
      op_q     <= operation;
      region_q <= shift_region_flag;
    end
  end

  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign sel_mux_1 = !iter_first;
  assign sel_mux_2 = var_idx;
  assign sel_mux_3 = op_q ^ region_swaps(region_q);

  always_comb begin
    state_nxt        = state;
    ready_cordic     = 1'b0;
    beg_add_subt     = 1'b0;
    ack_add_subt     = 1'b0;
    beg_mult         = 1'b0;
    enab_rb1         = 1'b0;
    enab_rb2         = 1'b0;
    enab_d_ff_xn     = 1'b0;
    enab_d_ff_yn     = 1'b0;
    enab_d_ff_zn     = 1'b0;
    enab_dff_shifted = 1'b0;
    enab_dff_lut     = 1'b0;
    enab_dff_sign    = 1'b0;
    enab_d_ff_out    = 1'b0;
    case (state)
      ST_IDLE:   if (beg_fsm_cordic) state_nxt = ST_LOAD;
      ST_LOAD: begin
        enab_rb1  = 1'b1;
        state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        enab_rb2         = 1'b1;
        enab_dff_shifted = 1'b1;
        enab_dff_lut     = 1'b1;
        enab_dff_sign    = 1'b1;
        state_nxt        = ST_ADD_ST;
      end
      ST_ADD_ST: begin
        beg_add_subt = 1'b1;
        state_nxt    = ST_ADD_WT;
      end
      ST_ADD_WT: if (ready_add_subt) state_nxt = ST_STORE;
      ST_STORE: begin
        ack_add_subt = 1'b1;
        enab_d_ff_xn = (var_idx == VAR_X);
        enab_d_ff_yn = (var_idx == VAR_Y);
        enab_d_ff_zn = (var_idx == VAR_Z);
        if (!var_last)       state_nxt = ST_ADD_ST;
        else if (!iter_last) state_nxt = ST_SETUP;
`ifdef CORDIC_GAIN_COMP_EN
        else                 state_nxt = ST_GAIN;
`else
        else                 state_nxt = ST_OUT;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      ST_GAIN: begin
        beg_mult  = 1'b1;
        state_nxt = ST_GWT;
      end
      ST_GWT:    if (ready_mult) state_nxt = ST_OUT;
`endif
      ST_OUT: begin
        enab_d_ff_out = 1'b1;
        state_nxt     = ST_DONE;
      end
      ST_DONE: begin
        ready_cordic = 1'b1;
        // ack takes priority; a fresh beg must be seen again in IDLE
        if (ack_fsm_cordic) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_ctrl_fsm_p.sv
module tb_cordic_ctrl_fsm_p;
  localparam int N_ITER = 4;
  localparam int ITER_W = 3;
  localparam int N_VAR  = 3;
  localparam int K      = N_ITER * N_VAR;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int GAIN_LAT = 4;
`else
  localparam int GAIN_LAT = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic beg_fsm_cordic = 1'b0, ack_fsm_cordic = 1'b0, operation = 1'b0, mode_in = 1'b0;
  logic [1:0] shift_region_flag = 2'b00;
  logic ready_add_subt = 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
  logic ready_mult = 1'b0;
`endif
  logic ready_cordic, busy, beg_add_subt, ack_add_subt, beg_mult;
  logic [ITER_W-1:0] iter_idx;
  logic [1:0] var_idx, sel_mux_2;
  logic sel_mux_1, sel_mux_3, mode;
  logic enab_rb1, enab_rb2, enab_d_ff_xn, enab_d_ff_yn, enab_d_ff_zn;
  logic enab_dff_shifted, enab_dff_lut, enab_dff_sign, enab_d_ff_out;

  cordic_ctrl_fsm_p #(.N_ITER(N_ITER), .ITER_W(ITER_W), .N_VAR(N_VAR)) dut (
    .clk(clk), .reset(reset),
    .beg_fsm_cordic(beg_fsm_cordic), .ack_fsm_cordic(ack_fsm_cordic),
    .operation(operation), .mode_in(mode_in), .shift_region_flag(shift_region_flag),
    .ready_add_subt(ready_add_subt),
`ifdef CORDIC_GAIN_COMP_EN
    .ready_mult(ready_mult),
`endif
    .ready_cordic(ready_cordic), .busy(busy), .beg_add_subt(beg_add_subt),
    .ack_add_subt(ack_add_subt), .beg_mult(beg_mult), .iter_idx(iter_idx),
    .var_idx(var_idx), .sel_mux_1(sel_mux_1), .sel_mux_2(sel_mux_2),
    .sel_mux_3(sel_mux_3), .mode(mode), .enab_rb1(enab_rb1), .enab_rb2(enab_rb2),
    .enab_d_ff_xn(enab_d_ff_xn), .enab_d_ff_yn(enab_d_ff_yn), .enab_d_ff_zn(enab_d_ff_zn),
    .enab_dff_shifted(enab_dff_shifted), .enab_dff_lut(enab_dff_lut),
    .enab_dff_sign(enab_dff_sign), .enab_d_ff_out(enab_d_ff_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    bit       op;
    bit [1:0] rg;
    bit       md;
    bit       fixed_w;
    bit       noise;
    bit       exp_sel3;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] all_outs();
    return {ready_cordic, busy, beg_add_subt, ack_add_subt, beg_mult, iter_idx, var_idx,
            sel_mux_1, sel_mux_2, sel_mux_3, mode, enab_rb1, enab_rb2, enab_d_ff_xn,
            enab_d_ff_yn, enab_d_ff_zn, enab_dff_shifted, enab_dff_lut, enab_dff_sign,
            enab_d_ff_out};
  endfunction

  // Reference: one operation is LOAD, then per iteration one SETUP cycle plus,
  // per variable, start + W wait cycles + store, then OUT (and gain), then DONE.
  task automatic run_op(input vec_t v, input string tag, output int rdy_cyc);
    int w[K];
    int exp_lat, nb, ns, na, nrb1, nrb2, nout, out_cyc, pend, bad_pair, bad_busy, bad_setup, bad_store;
`ifdef CORDIC_GAIN_COMP_EN
    int pend_m = -1;
`endif
    exp_lat = 3 + N_ITER + GAIN_LAT;
    for (int k = 0; k < K; k++) begin
      w[k] = v.fixed_w ? 1 : int'($urandom_range(1, 3));
      exp_lat += 2 + w[k];
    end
    {nb, ns, na, nrb1, nrb2, nout, bad_pair, bad_busy, bad_setup, bad_store} = '0;
    out_cyc = -1; pend = -1; rdy_cyc = -1;
    cyc = 0;
    operation = v.op; shift_region_flag = v.rg; mode_in = v.md;
    beg_fsm_cordic = 1'b1;
    for (int t = 0; t < 1500 && rdy_cyc < 0; t++) begin
      step();
      beg_fsm_cordic = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      ack_fsm_cordic = v.noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (ready_cordic) rdy_cyc = cyc;
      else if (!busy) bad_busy++;
      if (beg_add_subt) begin
        if (nb < K) begin
          if (iter_idx != ITER_W'(nb / N_VAR) || var_idx != 2'(nb % N_VAR) ||
              sel_mux_1 != (nb >= N_VAR) || sel_mux_2 != 2'(nb % N_VAR)) bad_pair++;
          pend = cyc + w[nb];
        end
        nb++;
      end
      if (enab_d_ff_xn | enab_d_ff_yn | enab_d_ff_zn) begin
        if ({enab_d_ff_zn, enab_d_ff_yn, enab_d_ff_xn} != (3'b001 << (ns % N_VAR))) bad_store++;
        ns++;
      end
      if (ack_add_subt) na++;
      if (enab_rb1) nrb1++;
      if (enab_rb2) nrb2++;
      if (enab_rb2 != enab_dff_shifted || enab_rb2 != enab_dff_lut || enab_rb2 != enab_dff_sign)
        bad_setup++;
      if (enab_d_ff_out) begin nout++; out_cyc = cyc; end
`ifdef CORDIC_GAIN_COMP_EN
      if (beg_mult) pend_m = cyc + 3;
      ready_mult = (cyc == pend_m);
`endif
      ready_add_subt = (cyc == pend) || (v.noise && enab_rb2);
    end
    beg_fsm_cordic = 1'b0; ack_fsm_cordic = 1'b0; ready_add_subt = 1'b0;
`ifdef CORDIC_GAIN_COMP_EN
    ready_mult = 1'b0;
`endif
    if (rdy_cyc < 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_latency"}, rdy_cyc, exp_lat);
    chk({tag, "_beg_add"}, nb, K);
    chk({tag, "_stores"}, ns, K);
    chk({tag, "_ack_add"}, na, K);
    chk({tag, "_rb1"}, nrb1, 1);
    chk({tag, "_rb2"}, nrb2, N_ITER);
    chk({tag, "_out_cnt"}, nout, 1);
    chk({tag, "_out_cyc"}, out_cyc, exp_lat - 1);
    chk({tag, "_idx_bad"}, bad_pair, 0);
    chk({tag, "_store_bad"}, bad_store, 0);
    chk({tag, "_busy_bad"}, bad_busy, 0);
    chk({tag, "_setup_bad"}, bad_setup, 0);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_sel3"}, sel_mux_3, v.exp_sel3);
    chk({tag, "_mode"}, mode, v.md);
  endtask

  task automatic ack_done(input bit with_beg, input string tag);
    ack_fsm_cordic = 1'b1;
    beg_fsm_cordic = with_beg;
    step();
    chk({tag, "_ack_rdy"}, ready_cordic, 0);
    chk({tag, "_ack_busy"}, busy, 0);
    ack_fsm_cordic = 1'b0;
    beg_fsm_cordic = 1'b0;
    step();
    chk({tag, "_idle_stays"}, busy, 0);
  endtask

  vec_t tbl[6];
  vec_t rv;
  int rc;

  initial begin
    tbl[0] = '{op: 1'b0, rg: 2'b00, md: 1'b0, fixed_w: 1'b1, noise: 1'b0, exp_sel3: 1'b0};
    tbl[1] = '{op: 1'b1, rg: 2'b01, md: 1'b1, fixed_w: 1'b0, noise: 1'b0, exp_sel3: 1'b0};
    tbl[2] = '{op: 1'b0, rg: 2'b10, md: 1'b0, fixed_w: 1'b0, noise: 1'b0, exp_sel3: 1'b1};
    tbl[3] = '{op: 1'b1, rg: 2'b11, md: 1'b1, fixed_w: 1'b0, noise: 1'b1, exp_sel3: 1'b1};
    tbl[4] = '{op: 1'b0, rg: 2'b01, md: 1'b1, fixed_w: 1'b0, noise: 1'b1, exp_sel3: 1'b1};
    tbl[5] = '{op: 1'b1, rg: 2'b00, md: 1'b0, fixed_w: 1'b1, noise: 1'b1, exp_sel3: 1'b1};

    // reset state
    repeat (3) step();
    chk("reset_outs", all_outs(), 0);
    reset = 1'b1;
    step();
    chk("idle_outs", all_outs(), 0);

    // table: each entry is a full operation, varied release sequences
    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i), rc);
      if (i == 0) begin
        chk("t1_lat_const", rc, 43 + GAIN_LAT);
        for (int j = 0; j < 20; j++) begin
          step();
          chk("done_hold", ready_cordic, 1);
        end
      end
      ack_done(i == 1 || tbl[i].noise, $sformatf("tbl%0d", i));
    end

    // randomized operations
    for (int i = 0; i < 5; i++) begin
      rv.op = 1'($urandom_range(0, 1));
      rv.rg = 2'($urandom_range(0, 3));
      rv.md = 1'($urandom_range(0, 1));
      rv.fixed_w = 1'b0;
      rv.noise = 1'($urandom_range(0, 1));
      rv.exp_sel3 = rv.op ^ (rv.rg == 2'b01 || rv.rg == 2'b10);
      run_op(rv, $sformatf("rnd%0d", i), rc);
      ack_done(1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    // reset in the middle of iteration 2
    begin
      int pend = -1;
      bit hit = 1'b0;
      cyc = 0;
      beg_fsm_cordic = 1'b1;
      for (int t = 0; t < 500 && !hit; t++) begin
        step();
        beg_fsm_cordic = 1'b0;
        if (beg_add_subt) begin
          pend = cyc + 1;
          if (iter_idx == ITER_W'(2)) hit = 1'b1;
        end
        ready_add_subt = (cyc == pend);
      end
      chk("rst_reach_iter2", hit, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_async_outs", all_outs(), 0);
      ready_add_subt = 1'b0;
      repeat (2) step();
      chk("rst_hold_outs", all_outs(), 0);
      reset = 1'b1;
      step();
      chk("rst_release_idle", busy, 0);
      run_op(tbl[0], "post_rst", rc);
      ack_done(1'b0, "post_rst");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
